// File: rtl/shift_pkg.sv
// shift_pkg: shared types, constants and bit-reverse helper for the shift sequencer
//   XLEN          - datapath width (32)
//   shift_op_e    - SLL / SRL / SRA / RSVD (reserved, executed as SLL)
//   shift_state_e - IDLE / SHIFT / DONE
//   bit_rev()     - reverses bit order so right shifts can reuse the left shifter
package shift_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, RSVD = 2'b11} shift_op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_e;
    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = d[XLEN-1-i];
        return r;
    endfunction
endpackage

// File: rtl/shift_left.sv
// shift_left: shared logical left-shift datapath
//   i_data [31:0] - operand
//   i_amt  [31:0] - shift amount
//   o_data [31:0] - i_data << i_amt
module shift_left
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [XLEN-1:0] i_amt,
    output logic [XLEN-1:0] o_data
);
    assign o_data = i_data << i_amt;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA controller, at most STEP bits per cycle
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake (req_op, req_data, req_shamt)
//   rsp_valid/rsp_ready              - response handshake (rsp_data)
//   busy                             - high in SHIFT or DONE
//   SHIFT_SEQUENCER_SRA_EN (define)  - enables SRA sign fill; otherwise SRA acts as SRL
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_data,
    input  logic [4:0]      req_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);
    localparam int SW = $clog2(STEP) + 1;

    shift_state_e    r_state, w_next;
    shift_op_e       r_op;
    logic [XLEN-1:0] r_acc;
    logic [4:0]      r_rem, w_rem_next;
    logic [SW-1:0]   w_step;
    logic [XLEN-1:0] w_amt, w_shifted, w_fill;
    logic            w_right, w_req_right;

    assign w_step      = (32'(r_rem) > STEP) ? SW'(STEP) : SW'(r_rem);
    assign w_amt       = XLEN'(w_step);
    assign w_rem_next  = r_rem - 5'(w_step);
    // Right shifts run on the bit-reversed operand through the left shifter
    assign w_right     = (r_op == SRL) || (r_op == SRA);
    assign w_req_right = (req_op == 2'b01) || (req_op == 2'b10);

    shift_left u_shift_left (
        .i_data(r_acc),
        .i_amt (w_amt),
        .o_data(w_shifted)
    );

`ifdef SHIFT_SEQUENCER_SRA_EN
    logic r_sign;
    // In reversed space the vacated low bits are the arithmetic fill positions
    assign w_fill = (r_op == SRA && r_sign) ? ~({XLEN{1'b1}} << w_amt) : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sign <= 1'b0;
        else if (r_state == IDLE && req_valid) r_sign <= req_data[XLEN-1];
`else
    assign w_fill = '0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = (req_shamt == 5'd0) ? DONE : SHIFT;
            SHIFT:   if (w_rem_next == 5'd0) w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = r_state == IDLE;
        busy      = r_state != IDLE;
        rsp_valid = r_state == DONE;
        rsp_data  = rsp_valid ? (w_right ? bit_rev(r_acc) : r_acc) : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_op  <= SLL;
        end else if (r_state == IDLE && req_valid) begin
            r_acc <= w_req_right ? bit_rev(req_data) : req_data;
            r_rem <= req_shamt;
            r_op  <= shift_op_e'(req_op);
        end else if (r_state == SHIFT) begin
            r_acc <= w_shifted | w_fill;
            r_rem <= w_rem_next;
        end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer (STEP=8)
module tb_shift_sequencer;
    logic        clk = 0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]  req_op;
    logic [31:0] req_data, rsp_data;
    logic [4:0]  req_shamt;
    int          checks = 0;
    int          failures = 0;

    shift_sequencer #(.STEP(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                           input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        logic bad;
        req_op = op; req_data = d; req_shamt = sh; req_valid = 1; rsp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        bad = 0;
        while (!rsp_valid && lat < 40) begin
            if (req_ready || !busy) bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_busy_noready"}, {31'd0, bad}, 32'd0);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rsp_data, exp);
        @(posedge clk); #1;
        chk({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_post_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 0; req_valid = 0; rsp_ready = 0; req_op = 0; req_data = 0; req_shamt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        run_req(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, "sll31");
`ifdef SHIFT_SEQUENCER_SRA_EN
        run_req(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, "sra4");
`else
        run_req(2'b10, 32'h8000_0000, 5'd4, 32'h0800_0000, 2, "sra4");
`endif
        run_req(2'b10, 32'h7000_0000, 5'd9, 32'h0038_0000, 3, "sra_pos9");
        run_req(2'b01, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 3, "srl16");
        run_req(2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 5, "srl31");
        run_req(2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, "sll0");
        run_req(2'b11, 32'h1234_5678, 5'd8, 32'h3456_7800, 2, "rsvd8");

        // Backpressure: a second request stays offered while the first is held in DONE
        req_op = 2'b00; req_data = 32'h0000_00FF; req_shamt = 5'd4; req_valid = 1; rsp_ready = 0;
        @(posedge clk); #1;
        req_op = 2'b01; req_data = 32'hF000_0000; req_shamt = 5'd20;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_data", rsp_data, 32'h0000_0FF0);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        chk("bp_accept_busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp2_lat", lat, 4);
        chk("bp2_data", rsp_data, 32'h0000_0F00);
        @(posedge clk); #1;

        // Reset in the middle of a long shift abandons it
        req_op = 2'b00; req_data = 32'h0000_0001; req_shamt = 5'd31; req_valid = 1; rsp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        chk("midrst_idle_ready", {31'd0, req_ready}, 32'd1);

        run_req(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 5, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
